// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and op-class helpers shared by the multiply/divide unit
package muldiv_pkg;
    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX, ST_DONE} state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return op == MULDIV_MULH || op == MULDIV_MULHSU || op == MULDIV_DIV || op == MULDIV_REM;
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return op == MULDIV_MULH || op == MULDIV_DIV || op == MULDIV_REM;
    endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: start/busy/done request and result bundle between control unit and muldiv_unit
interface muldiv_if #(parameter int XLEN = 32);
    logic            i_start;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_a;
    logic [XLEN-1:0] i_b;
    logic            o_busy;
    logic            o_done;
    logic [XLEN-1:0] o_result;

    modport master(output i_start, i_op, i_a, i_b, input o_busy, o_done, o_result);
    modport slave(input i_start, i_op, i_a, i_b, output o_busy, o_done, o_result);
endinterface

// File: rtl/muldiv_abs.sv
// muldiv_abs: conditional two's-complement negate
module muldiv_abs #(parameter int XLEN = 32) (
    input  logic            i_neg,
    input  logic [XLEN-1:0] i_val,
    output logic [XLEN-1:0] o_val
);
    assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: bit-serial RV32M/RV64M multiply/divide; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN)
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    state_t            r_state, w_next;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [XLEN-1:0]   r_opb, r_result;
    logic [2*XLEN-1:0] r_prod, w_step;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_accept, w_sa, w_sb, w_div0, w_ovf, w_fast;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_short_val, w_fast_val;
    logic [XLEN-1:0]   w_lo, w_hi, w_sel, w_fixed, w_fix_val;
    logic [XLEN:0]     w_sum, w_diff;

    assign w_accept = bus.i_start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_sa     = is_signed_a(bus.i_op) & bus.i_a[XLEN-1];
    assign w_sb     = is_signed_b(bus.i_op) & bus.i_b[XLEN-1];
    assign w_div0   = is_div(bus.i_op) && bus.i_b == '0;
    assign w_ovf    = (bus.i_op == MULDIV_DIV || bus.i_op == MULDIV_REM) &&
                      bus.i_a == {1'b1, {(XLEN-1){1'b0}}} && &bus.i_b;
    assign w_short_val = w_div0 ? (bus.i_op[1] ? bus.i_a : '1) : (bus.i_op[1] ? '0 : bus.i_a);

    muldiv_abs #(.XLEN(XLEN)) u_abs_a (.i_neg(w_sa), .i_val(bus.i_a), .o_val(w_mag_a));
    muldiv_abs #(.XLEN(XLEN)) u_abs_b (.i_neg(w_sb), .i_val(bus.i_b), .o_val(w_mag_b));

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     w_fa, w_fb;
    logic signed [2*XLEN-1:0] w_fp;
    assign w_fa       = {w_sa, bus.i_a};
    assign w_fb       = {w_sb, bus.i_b};
    assign w_fp       = w_fa * w_fb;
    assign w_fast     = !is_div(bus.i_op);
    assign w_fast_val = bus.i_op == MULDIV_MUL ? w_fp[XLEN-1:0] : w_fp[2*XLEN-1:XLEN];
`else
    assign w_fast     = 1'b0;
    assign w_fast_val = '0;
`endif

    // mul: shift-add into upper half; div: restoring step on {remainder, quotient}
    assign w_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, r_opb};
    assign w_diff = r_prod[2*XLEN-1:XLEN-1] - {1'b0, r_opb};
    assign w_step = is_div(r_op)
        ? (w_diff[XLEN] ? {r_prod[2*XLEN-2:0], 1'b0} : {w_diff[XLEN-1:0], r_prod[XLEN-2:0], 1'b1})
        : (r_prod[0] ? {w_sum, r_prod[XLEN-1:1]} : {1'b0, r_prod[2*XLEN-1:1]});

    assign w_lo  = r_prod[XLEN-1:0];
    assign w_hi  = r_prod[2*XLEN-1:XLEN];
    assign w_sel = (r_op == MULDIV_MUL || (is_div(r_op) && !r_op[1])) ? w_lo : w_hi;

    muldiv_abs #(.XLEN(XLEN)) u_abs_r (.i_neg(r_neg), .i_val(w_sel), .o_val(w_fixed));

    // high half of a negated 2*XLEN product only takes the +1 carry when the low half is zero
    assign w_fix_val = (!is_div(r_op) && r_op != MULDIV_MUL && r_neg && w_lo != '0) ? ~w_hi : w_fixed;

    always_comb begin
        w_next = r_state;
        if (w_accept)
            w_next = (w_div0 || w_ovf || w_fast) ? ST_DONE : ST_RUN;
        else if (r_state == ST_DONE)
            w_next = ST_IDLE;
        else if (r_state == ST_RUN)
            w_next = r_cnt == '0 ? ST_FIX : ST_RUN;
        else if (r_state == ST_FIX)
            w_next = ST_DONE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_opb    <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op   <= bus.i_op;
            r_neg  <= (is_div(bus.i_op) && bus.i_op[1]) ? w_sa : w_sa ^ w_sb;
            r_opb  <= is_div(bus.i_op) ? w_mag_b : w_mag_a;
            r_prod <= {{XLEN{1'b0}}, is_div(bus.i_op) ? w_mag_a : w_mag_b};
            r_cnt  <= CNT_W'(XLEN-1);
            if (w_div0 || w_ovf)
                r_result <= w_short_val;
            else if (w_fast)
                r_result <= w_fast_val;
        end else if (r_state == ST_RUN) begin
            r_prod <= w_step;
            r_cnt  <= r_cnt - 1'b1;
        end else if (r_state == ST_FIX) begin
            r_result <= w_fix_val;
        end
    end

    assign bus.o_busy   = r_state == ST_RUN || r_state == ST_FIX;
    assign bus.o_done   = r_state == ST_DONE;
    assign bus.o_result = r_result;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide execution unit, parametrised in operand width.
- Sits beside the combinational arithmetic unit in the execute stage.
- Accepts one operation via a start/busy/done handshake and computes it bit-serially, one bit per cycle.
- The control unit stalls the pipeline while the unit is busy.

Parameters:
- XLEN, 32, operand and result width; legal values 32 and 64.
- CNT_W, $clog2(XLEN), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request; sampled only when busy=0.
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 operand.
- b  in  XLEN  rs2 operand.
- busy  out  1  high while an operation is in flight (RUN or FIX).
- done  out  1  single-cycle pulse; result is valid in this cycle.
- result  out  XLEN  operation result; held until the next accepted start.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; busy=0, done=0, result=0.
  - All internal accumulators and the counter are cleared.
  - Reset asserted mid-operation aborts the operation; no done is emitted.
- States: IDLE, RUN, FIX, DONE.
  - busy=1 in RUN and FIX.
  - done=1 only in DONE.
- IDLE or DONE with start=1:
  - a, b and op are latched; later input changes are ignored.
  - Signed ops (MULH, MULHSU-a, DIV, REM) take operand magnitudes.
  - Result sign and remainder sign are recorded.
  - Counter loads XLEN-1; next state is RUN.
- IDLE or DONE with start=0: DONE goes to IDLE; IDLE stays.
- RUN:
  - Multiply: one shift-add step per cycle into a 2*XLEN product register.
  - Divide: one restoring step per cycle (shift remainder, trial subtract, set quotient bit).
  - Counter decrements; at count 0 the next state is FIX.
  - Exactly XLEN cycles are spent in RUN.
- FIX:
  - Applies two's-complement negation where the recorded sign requires it.
  - Selects the output: MUL takes the low half; MULH, MULHSU and MULHU take the high half; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Result is registered; next state is DONE.
- Latency (start cycle = cycle 0):
  - Normal: done=1 in cycle XLEN+2 (34 for XLEN=32).
  - Back-to-back: start in the DONE cycle is accepted; no idle gap.
- start while busy=1 is ignored; no queuing, no error.
- Shortcut cases (detected at accept) go directly to DONE, done=1 in cycle 1:
  - Divide by zero (b=0): DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (a=most-negative, b=all-ones, DIV/REM): DIV gives a; REM gives 0.
- Arithmetic:
  - Signed result correction: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - MULHSU treats only a as signed.
  - All intermediate widths are sized to 2*XLEN or XLEN+1; no truncation before output selection.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: the four multiply ops use a single-cycle combinational 2*XLEN multiplier (a (XLEN+1)x(XLEN+1) signed product with per-op sign extension). Accept goes straight to DONE, so done=1 in cycle 1. Divide ops are unchanged.
- Undefined: all multiplies are iterative at XLEN+2 latency, and no hardware multiplier is inferred.

Decomposition:
- Package muldiv_pkg holds:
  - the op encoding localparams (MULDIV_MUL … MULDIV_REMU);
  - the state encoding (ST_IDLE, ST_RUN, ST_FIX, ST_DONE);
  - helper functions is_div(op), is_signed_a(op), is_signed_b(op).
- One natural sub-module: muldiv_abs, a combinational XLEN-wide conditional two's-complement negate. It is instantiated for operand magnitude at accept and for result correction in FIX.

Test Plan:
- XLEN=32, MUL a=7, b=0xFFFFFFFD → result=0xFFFFFFEB; done exactly in cycle 34; busy high cycles 1–33.
- MULH a=b=0x80000000 → 0x40000000. MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Shortcuts, each with done in cycle 1:
  - DIVU a=5, b=0 → 0xFFFFFFFF; REM a=5, b=0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Start pulsed during busy, with inputs changed mid-operation → ignored; the original result completes. Start in the DONE cycle → second op accepted; its done appears 34 cycles later.
- rst asserted in cycle 10 of a DIV → busy, done and result go to 0 immediately (asynchronous); no done afterwards. A new start after rst deasserts completes correctly.
